// File: rtl/ipf_pkg.sv
// Shared definitions for the IPF result drain path.
//   IPF_RES_W : width of one IPF result word
//   IPF_OUT_W : width of one beat towards the result memory writer
//   IPF_BEATS : beats per result
//   drain_state_t : drain controller states
package ipf_pkg;

  localparam int IPF_RES_W = 1152;
  localparam int IPF_OUT_W = 64;
  localparam int IPF_BEATS = IPF_RES_W / IPF_OUT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } drain_state_t;

endpackage

// File: rtl/ipf_res_fifo.sv
// Small synchronous FIFO holding whole IPF result words.
//   clk, rst     : clock, synchronous active-low reset
//   push, wdata  : write strobe and word (caller guarantees !full || pop)
//   pop, rdata   : read strobe and head word (rdata shows the head combinationally)
//   full, empty  : occupancy flags
//   count        : number of stored words
// A push while full is legal when a pop happens on the same edge.
module ipf_res_fifo #(
  parameter int W     = 1152,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ipf_res_drain.sv
// Drain for IPF results: buffers results and serializes each into 64-bit
// beats with word addresses for the result memory writer.
//   clk, rst           : clock, synchronous active-low reset
//   res_valid, res     : IPF result strobe and word (no backpressure)
//   o_valid, o_ready   : beat handshake
//   o_data, o_addr     : beat data and word address
//   done               : sticky, ANS_NUM results fully written
//   overflow           : sticky, a result was dropped
//
// state | meaning
// IDLE  | buffer empty, nothing offered
// SEND  | offering beats of the head result
// DONE  | frame complete, all further results dropped until reset
module ipf_res_drain
  import ipf_pkg::*;
#(
  parameter int RES_W   = IPF_RES_W,
  parameter int OUT_W   = IPF_OUT_W,
  parameter int DEPTH   = 2,
  parameter int A_Width = 16,
  parameter int ANS_NUM = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_valid,
  input  logic [RES_W-1:0]   res,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [OUT_W-1:0]   o_data,
  output logic [A_Width-1:0] o_addr,
  output logic               done,
  output logic               overflow
);

  localparam int BEATS = RES_W / OUT_W;
  localparam int BW    = $clog2(BEATS);
  localparam int IW    = $clog2(ANS_NUM + 1);
  localparam int CW    = $clog2(DEPTH + 1);

  drain_state_t state, state_nxt;

  logic [BW-1:0]    beat_cnt;
  logic [IW-1:0]    res_idx;
  logic [RES_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             xfer;
  logic             last_xfer;
  logic             push;
  logic [OUT_W-1:0] beat_word [BEATS];

  assign xfer      = o_valid && o_ready;
  assign last_xfer = xfer && (beat_cnt == BW'(BEATS - 1));
  // A full buffer still takes a result when the head leaves on this edge.
  assign push      = res_valid && (state != DONE) && (!fifo_full || last_xfer);

  ipf_res_fifo #(
    .W     (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (res),
    .pop   (last_xfer),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  for (genvar k = 0; k < BEATS; k++) begin : g_beat
    assign beat_word[k] = head[k*OUT_W +: OUT_W];
  end

  // Data/address come from registered counters only, so they hold during stalls.
  assign o_data = o_valid ? beat_word[beat_cnt] : '0;
  assign o_addr = o_valid ? (A_Width'(res_idx) * A_Width'(BEATS) + A_Width'(beat_cnt)) : '0;

  always_comb begin
    state_nxt = state;
    o_valid   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (push || !fifo_empty) state_nxt = SEND;
      end
      SEND: begin
        o_valid = 1'b1;
        if (last_xfer) begin
          if (res_idx == IW'(ANS_NUM - 1))           state_nxt = DONE;
          else if ((fifo_count > CW'(1)) || push)    state_nxt = SEND;
          else                                       state_nxt = IDLE;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      res_idx  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (last_xfer) begin
        beat_cnt <= '0;
        res_idx  <= res_idx + IW'(1);
      end else if (xfer) begin
        beat_cnt <= beat_cnt + BW'(1);
      end
      if (res_valid && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ipf_res_drain.sv
module tb_ipf_res_drain;

  localparam int RW = 1152;
  localparam int NB = 18;
  localparam int NANS = 64;

  logic            clk;
  logic            rst;
  logic            res_valid;
  logic [RW-1:0]   res;
  logic            o_valid;
  logic            o_ready;
  logic [63:0]     o_data;
  logic [15:0]     o_addr;
  logic            done;
  logic            overflow;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of buffered results plus progress counters.
  logic [RW-1:0] mq[$];
  int            m_beat;
  int            m_idx;
  bit            m_done;
  bit            m_ovf;

  ipf_res_drain dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res       (res),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_addr    (o_addr),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (idx=%0d beat=%0d)", tag, obs, exp, m_idx, m_beat);
    end
  endtask

  function automatic logic [RW-1:0] pat_res();
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[k*64 +: 64] = 64'(k);
    return r;
  endfunction

  function automatic logic [RW-1:0] rnd_res();
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < RW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit rv, input logic [RW-1:0] r, input bit rdy, input bit rb);
    bit            ev;
    bit            xf;
    bit            lst;
    bit            acc;
    logic [RW-1:0] hd;
    logic [63:0]   ed;
    logic [63:0]   ea;
    rst       = rb;
    res_valid = rv;
    res       = r;
    o_ready   = rdy;
    #4;
    ev = !m_done && (mq.size() > 0);
    ed = '0;
    ea = '0;
    if (ev) begin
      hd = mq[0];
      ed = hd[m_beat*64 +: 64];
      ea = 64'(m_idx * NB + m_beat);
    end
    chk("o_valid",  64'(o_valid),  64'(ev));
    chk("o_data",   o_data,        ed);
    chk("o_addr",   64'(o_addr),   ea);
    chk("done",     64'(done),     64'(m_done));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (!rb) begin
      mq.delete();
      m_beat = 0;
      m_idx  = 0;
      m_done = 0;
      m_ovf  = 0;
    end else begin
      xf  = ev && rdy;
      lst = xf && (m_beat == NB - 1);
      acc = rv && !m_done && ((mq.size() < 2) || lst);
      if (xf) begin
        if (lst) begin
          void'(mq.pop_front());
          m_beat = 0;
          m_idx++;
          if (m_idx == NANS) m_done = 1;
        end else begin
          m_beat++;
        end
      end
      if (acc) mq.push_back(r);
      else if (rv) m_ovf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; res_valid = 1'b0; res = '0; o_ready = 1'b0;
    m_beat = 0; m_idx = 0; m_done = 0; m_ovf = 0;
    @(posedge clk);
    #1;
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);

    // Single patterned result, writer always ready.
    step(1, pat_res(), 1, 1);
    repeat (22) step(0, '0, 1, 1);

    // Same result with ready toggling every cycle.
    step(0, '0, 0, 0);
    step(1, pat_res(), 0, 1);
    for (int i = 0; i < 44; i++) step(0, '0, (i % 2) == 1, 1);

    // Three back-to-back results while stalled: third is dropped.
    step(0, '0, 0, 0);
    step(1, rnd_res(), 0, 1);
    step(1, rnd_res(), 0, 1);
    step(1, rnd_res(), 0, 1);
    repeat (5) step(0, '0, 0, 1);
    repeat (42) step(0, '0, 1, 1);

    // Full buffer with beat 17 leaving on the same edge as a new result.
    step(0, '0, 0, 0);
    step(1, rnd_res(), 0, 1);
    step(1, rnd_res(), 0, 1);
    for (int i = 0; i < 40; i++) begin
      if (m_beat == NB - 1 && mq.size() == 2) break;
      step(0, '0, 1, 1);
    end
    step(1, rnd_res(), 1, 1);
    repeat (40) step(0, '0, 1, 1);

    // Reset during beat 5 of result 2, then a fresh result from address 0.
    step(0, '0, 0, 0);
    for (int c = 0; c < 100; c++) begin
      if (m_idx == 2 && m_beat == 5) break;
      step((c % NB == 0) && (c < 3 * NB), rnd_res(), 1, 1);
    end
    step(0, '0, 1, 0);
    step(1, rnd_res(), 1, 1);
    repeat (22) step(0, '0, 1, 1);

    // Random traffic and backpressure.
    step(0, '0, 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) == 0, rnd_res(), $urandom_range(0, 3) != 0, 1);

    // Full frame: 64 results, then one extra that must be dropped.
    step(0, '0, 0, 0);
    for (int n = 0; n < NANS; n++) begin
      step(1, rnd_res(), 1, 1);
      repeat (19) step(0, '0, 1, 1);
    end
    step(1, rnd_res(), 1, 1);
    repeat (25) step(0, '0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
